// File: rtl/mem_seq_pkg.sv
// Shared types for the memory sequencer: FSM state encoding and requester identity.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; remembers who was served last so that a tie
// goes to the other requester.
module rr_arb2
  import mem_seq_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic req_if,
  input  logic req_dm,
  input  logic update,
  input  logic owner,
  output logic winner,
  output logic valid
);

  gnt_t last;

  // Starting from "data served last" hands the first tie to the fetch side.
  always_ff @(posedge Clk) begin
    if (!Reset)      last <= GNT_DM;
    else if (update) last <= gnt_t'(owner);
  end

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    valid  = req_if | req_dm;
    winner = req_dm;
    if (req_if && req_dm) winner = (last == GNT_DM) ? GNT_IF : GNT_DM;
  end

endmodule

// File: rtl/mem_sequencer.sv
// Shares one single-port memory between instruction fetch and load/store,
// hiding the fixed read latency behind a request / one-cycle-ack handshake.
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant,
  output logic [1:0]    StateOut
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          win;
  logic          win_valid;

  rr_arb2 u_arb (
    .Clk    (Clk),
    .Reset  (Reset),
    .req_if (if_req),
    .req_dm (dm_req),
    .update (state == RESP),
    .owner  (grant),
    .winner (win),
    .valid  (win_valid)
  );

  assign StateOut = state;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      rdata     <= '0;
      grant     <= GNT_IF;
      busy      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant <= win;
            busy  <= 1'b1;
            state <= ACCESS;
            if (win == GNT_DM) begin
              mem_addr  <= dm_addr;
              mem_wr    <= dm_wr;
              mem_wdata <= dm_wdata;
              cnt       <= dm_wr ? '0 : CW'(MEM_LAT);
            end else begin
              mem_addr <= if_addr;
              mem_wr   <= 1'b0;
              cnt      <= CW'(MEM_LAT);
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            // Stores have a zero count, so the strobe lives for one cycle only.
            if (!mem_wr) rdata <= mem_rdata;
            mem_wr <= 1'b0;
            if_ack <= (grant == GNT_IF);
            dm_ack <= (grant == GNT_DM);
            state  <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: latency-accurate memory model plus a transaction-level
// reference (word array, last-served owner, last read value).
module tb_mem_sequencer;

  localparam int MEM_LAT = 2;
  localparam int RD_LAT  = 2 + MEM_LAT;
  localparam int WR_LAT  = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        if_ack, dm_ack, mem_wr, busy, grant;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  StateOut;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe    [MEM_LAT];
  logic        mem_load = 1'b1;

  int          checks = 0;
  int          errors = 0;
  logic        ref_last;
  logic [31:0] exp_rdata;

  mem_sequencer #(.MEM_LAT(MEM_LAT), .AW(32), .DW(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant(grant), .StateOut(StateOut)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h8C02_0004;
    return 32'h9E37_79B9 * 32'(i + 1);
  endfunction

  // Memory: data for an address appears MEM_LAT cycles after it is presented.
  always @(posedge Clk) begin
    if (mem_load) for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    pipe[0] <= mem[mem_addr[9:2]];
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  function automatic int lat(input logic wr);
    return wr ? WR_LAT : RD_LAT;
  endfunction

  // Waits for one transaction's ack; exp_n counts negedges from the call.
  task automatic serve(input string name, input logic owner, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata, input int exp_n);
    int          n = 0;
    int          wr_cnt = 0;
    int          wr_n = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    bit          got = 0;
    while (!got && n < exp_n + 8) begin
      @(negedge Clk);
      n++;
      if (mem_wr) begin
        wr_cnt++; wr_n = n; wr_addr = mem_addr; wr_data = mem_wdata;
      end
      if (if_ack || dm_ack) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ack_timeout: no ack after %0d cycles, required one by %0d", name, n, exp_n);
      return;
    end
    checks++;
    if (n !== exp_n) begin
      errors++; $display("FAIL %s ack_cycle: got %0d required %0d", name, n, exp_n);
    end
    checks++;
    if ({if_ack, dm_ack} !== {~owner, owner}) begin
      errors++; $display("FAIL %s ack_owner: if/dm ack %b%b required %b%b", name, if_ack, dm_ack, ~owner, owner);
    end
    checks++;
    if (grant !== owner) begin
      errors++; $display("FAIL %s grant: got %b required %b", name, grant, owner);
    end
    checks++;
    if (mem_addr !== addr) begin
      errors++; $display("FAIL %s mem_addr: got %h required %h", name, mem_addr, addr);
    end
    checks++;
    if (wr) begin
      if (wr_cnt !== 1 || wr_n !== exp_n - 1 || wr_addr !== addr || wr_data !== wdata) begin
        errors++;
        $display("FAIL %s store_strobe: count %0d at %0d addr %h data %h, required 1 at %0d addr %h data %h",
                 name, wr_cnt, wr_n, wr_addr, wr_data, exp_n - 1, addr, wdata);
      end
      ref_mem[addr[9:2]] = wdata;
    end else begin
      if (wr_cnt !== 0) begin
        errors++; $display("FAIL %s load_strobe: mem_wr count %0d required 0", name, wr_cnt);
      end
      exp_rdata = ref_mem[addr[9:2]];
    end
    checks++;
    if (rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rdata: got %h required %h", name, rdata, exp_rdata);
    end
    ref_last = owner;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    mem_load = 1'b0;
    checks++;
    if ({if_ack, dm_ack, mem_wr, busy, grant, StateOut, mem_addr, mem_wdata, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: acks %b%b wr %b busy %b grant %b state %0d addr %h wdata %h rdata %h, required all 0",
               if_ack, dm_ack, mem_wr, busy, grant, StateOut, mem_addr, mem_wdata, rdata);
    end
    Reset = 1'b1;
    ref_last = 1'b1;
    exp_rdata = '0;
  endtask

  task automatic test_fetch();
    if_addr = 32'h40; if_req = 1'b1;
    @(negedge Clk);
    checks++;
    if ({mem_addr, busy, StateOut} !== {32'h40, 1'b1, 2'd1}) begin
      errors++; $display("FAIL fetch_cycle1: addr %h busy %b state %0d required 00000040 1 1", mem_addr, busy, StateOut);
    end
    serve("fetch", 1'b0, 1'b0, 32'h40, '0, RD_LAT - 1);
    if_req = 1'b0;
    @(negedge Clk);
    checks++;
    if ({if_ack, dm_ack, busy, StateOut} !== 5'b0) begin
      errors++; $display("FAIL fetch_after_ack: acks %b%b busy %b state %0d required 0", if_ack, dm_ack, busy, StateOut);
    end
  endtask

  task automatic test_store();
    dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_wr = 1'b1; dm_req = 1'b1;
    serve("store", 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, WR_LAT);
    dm_req = 1'b0; dm_wr = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_mid_change();
    if_addr = 32'h40; if_req = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    if_addr = 32'h44;
    serve("mid_change", 1'b0, 1'b0, 32'h40, '0, RD_LAT - 2);
    if_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd;
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    ref_last = 1'b1;
    exp_rdata = '0;
    wd = $urandom;
    if_addr = 32'h80; if_req = 1'b1;
    dm_addr = 32'h200; dm_wdata = wd; dm_wr = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic o;
      o = (k % 2 == 1);
      serve($sformatf("b2b_%0d", k), o, o, o ? 32'h200 : 32'h80, wd, lat(o) + (k > 0 ? 1 : 0));
    end
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    if_addr = 32'h48; if_req = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if ({if_ack, dm_ack, mem_wr, busy, grant, StateOut, mem_addr, mem_wdata, rdata} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: acks %b%b busy %b state %0d addr %h rdata %h, required all 0",
               if_ack, dm_ack, busy, StateOut, mem_addr, rdata);
    end
    Reset = 1'b1; if_req = 1'b0;
    ref_last = 1'b1;
    exp_rdata = '0;
    repeat (RD_LAT + 2) begin
      @(negedge Clk);
      if (if_ack || dm_ack) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL abort_no_ack: saw %0d acks required 0", acks);
    end
    if_req = 1'b1;
    serve("after_abort", 1'b0, 1'b0, 32'h48, '0, RD_LAT);
    if_req = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_random();
    logic        ri, rd, first, w;
    logic [31:0] ia, da, wd;
    int          stray;
    for (int it = 0; it < 25; it++) begin
      stray = 0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge Clk);
        if (if_ack || dm_ack) stray++;
      end
      checks++;
      if (stray !== 0) begin
        errors++; $display("FAIL rand_%0d idle_ack: saw %0d acks required 0", it, stray);
      end
      ri = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!ri && !rd) ri = 1'b1;
      ia = 32'($urandom_range(0, 255)) << 2;
      da = 32'($urandom_range(0, 255)) << 2;
      wd = $urandom;
      w  = 1'($urandom_range(0, 1));
      if_addr = ia; if_req = ri;
      dm_addr = da; dm_wdata = wd; dm_wr = w; dm_req = rd;
      first = (ri && rd) ? ~ref_last : rd;
      if (first) begin
        serve($sformatf("rand_%0d_dm", it), 1'b1, w, da, wd, lat(w));
        dm_req = 1'b0;
        if (ri) begin
          serve($sformatf("rand_%0d_if", it), 1'b0, 1'b0, ia, '0, RD_LAT + 1);
          if_req = 1'b0;
        end
      end else begin
        serve($sformatf("rand_%0d_if", it), 1'b0, 1'b0, ia, '0, RD_LAT);
        if_req = 1'b0;
        if (rd) begin
          serve($sformatf("rand_%0d_dm", it), 1'b1, w, da, wd, lat(w) + 1);
          dm_req = 1'b0;
        end
      end
      dm_wr = 1'b0;
      @(negedge Clk);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_mid_change();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Sequences the single-port instruction/data memory of the multicycle MIPS core, sharing it between the instruction-fetch requester and the load/store requester of the control unit. It grants one requester at a time with round-robin tie-breaking. It latches the request, drives the memory for the fixed read latency, and returns a one-cycle acknowledge with registered read data. The control FSM therefore no longer has to encode the memory wait-state cycles itself.

## Interface
- MEM_LAT, 2, memory read latency in cycles from address presented to `mem_rdata` valid (≥1)
- AW, 32, address width
- DW, 32, data width
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with `if_addr` until `if_ack`
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle pulse, `rdata` valid for fetch
- dm_req  in  1  data request; held with fields until `dm_ack`
- dm_wr  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_ack  out  1  one-cycle pulse; for loads `rdata` valid
- rdata  out  DW  registered read data, holds until next read completes
- mem_addr  out  AW  registered memory address
- mem_wr  out  1  registered memory write strobe
- mem_wdata  out  DW  registered memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high when not IDLE
- grant  out  1  owner of current/last access, 0 = fetch, 1 = data
- StateOut  out  2  current state encoding, for debug

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE:**
  - With no request pending, stay in IDLE.
  - Otherwise choose a winner:
    - Only one request high: that requester wins.
    - Both high: the requester not granted last wins.
  - Latch the winner's address, write flag and write data into `mem_addr`, `mem_wr` and `mem_wdata`. Latch `grant`.
  - Load the wait counter with MEM_LAT for reads or 0 for writes, then go to ACCESS.
- **ACCESS:**
  - Counter nonzero: decrement it and stay in ACCESS.
  - Counter zero:
    - Read: capture `mem_rdata` into `rdata`.
    - Clear `mem_wr` and go to RESP.
  - `mem_wr` is high for exactly one ACCESS cycle per store.
- **RESP:**
  - Assert `if_ack` or `dm_ack` per `grant`.
  - Update the last-grant register, then go to IDLE.
- Request inputs are ignored outside IDLE. A change to `*_addr`/`dm_wdata` after the grant has no effect.
- If a requester still has `req` high in the IDLE cycle after its ack, that is a new transaction.
- `rdata` is unchanged by stores.
- Counter width is `$clog2(MEM_LAT+1)`. No address alignment check.
- `grant` holds between transactions.
- **Reset** (sync, `Reset`=0), any state including mid-ACCESS:
  - State goes to IDLE.
  - Zeroed: `if_ack`, `dm_ack`, `mem_wr`, `mem_addr`, `mem_wdata`, `rdata`, counter, `grant`, `busy`.
  - `StateOut` is set to the IDLE encoding (0).
  - Last-grant is set to data, so fetch wins the first tie.
  - An aborted store produces no further `mem_wr`.

## Timing
- Request first sampled high in IDLE at cycle 0 → ACCESS starts in cycle 1 with memory outputs valid.
- Read: `mem_rdata` is sampled at the end of cycle 1+MEM_LAT, and the ack plus `rdata` arrive in cycle 2+MEM_LAT. With MEM_LAT=2, the ack is in cycle 4.
- Write: `mem_wr` is high in cycle 1 only, and the ack is in cycle 2.
- Minimum spacing between acks: read MEM_LAT+3 cycles, write 3 cycles, because RESP is always followed by IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `StateOut` reflects the current state, not delayed.

## Structure
- Shared package `mem_seq_pkg`:
  - state enum {IDLE=0, ACCESS=1, RESP=2}
  - grant enum {GNT_IF=0, GNT_DM=1}
- Sub-module `rr_arb2`:
  - Two-input round-robin arbiter holding the last-grant register.
  - Inputs: `Clk`, `Reset`, both reqs, an update strobe.
  - Outputs: a winner and a valid signal.
- The rest is one FSM plus the counter in `mem_sequencer`.

## Test plan
- Fetch read, MEM_LAT=2: `if_req`=1, `if_addr`=0x40, memory returns 0x8C020004 → `mem_addr`=0x40 from cycle 1, `if_ack` one pulse in cycle 4, `rdata`=0x8C020004, `dm_ack` stays 0.
- Store: `dm_req`=1, `dm_wr`=1, `dm_addr`=0x100, `dm_wdata`=0xDEADBEEF → `mem_wr`=1 only in cycle 1 with that address/data, `dm_ack` in cycle 2, `rdata` unchanged.
- Simultaneous `if_req` and `dm_req` held high after reset → grants alternate IF, DM, IF, DM; each ack goes only to its owner.
- Request fields changed mid-ACCESS (`if_addr` 0x40→0x44 in cycle 2) → `mem_addr` stays 0x40, and the returned data belongs to 0x40.
- `Reset`=0 during ACCESS of a load → IDLE next cycle, all outputs 0, no ack issued; a fresh `if_req` then completes normally.
- MEM_LAT=1 build: fetch ack in cycle 3; MEM_LAT=4 build: fetch ack in cycle 6.
